// File: rtl/ddr2_req_queue.sv
// Client request FIFO in front of the DDR2 controller user port; replays one command at a time
// and returns read data through a one-entry response register. Optional counters: DDR2_REQ_QUEUE_STATS_EN.
module ddr2_req_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              c_rd_req,
    output logic              c_wr_req,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    input  logic              c_ack,
    input  logic              c_rdy,
`ifdef DDR2_REQ_QUEUE_STATS_EN
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
`endif
    input  logic [DATA_W-1:0] c_data_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE
    } state_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic             cmd_rd;

    entry_t           head_c;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    // FIFO status and handshake decisions
    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign req_ready = !full_c;
    assign push_c    = req_valid && !full_c;
    assign head_c    = mem[rd_ptr];
    // Reads wait for the response slot to drain; writes never produce a response
    assign pop_c     = (state == IDLE) && !empty_c && c_rdy && (head_c.we || !rsp_valid);

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        end
    end

    // Pointers wrap modulo DEPTH; count carries the extra bit for full/empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Command sequencer: issue, hold until ack, then wait for c_rdy low->high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c_rd_req  <= 1'b0;
            c_wr_req  <= 1'b0;
            c_addr    <= '0;
            c_data_in <= '0;
            cmd_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state     <= ISSUE;
                        c_addr    <= head_c.addr;
                        c_data_in <= head_c.we ? head_c.wdata : '0;
                        c_wr_req  <= head_c.we;
                        c_rd_req  <= !head_c.we;
                        cmd_rd    <= !head_c.we;
                    end
                end
                ISSUE: begin
                    if (c_ack) begin
                        c_wr_req <= 1'b0;
                        c_rd_req <= 1'b0;
                        state    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!c_rdy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (c_rdy) begin
                        state <= IDLE;
                        if (cmd_rd) begin
                            rsp_data  <= c_data_out;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DDR2_REQ_QUEUE_STATS_EN
    // Saturating per-type counts of acknowledged commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else if ((state == ISSUE) && c_ack) begin
            if (cmd_rd) begin
                if (stat_rd_cnt != 16'hFFFF) begin
                    stat_rd_cnt <= stat_rd_cnt + 16'd1;
                end
            end else begin
                if (stat_wr_cnt != 16'hFFFF) begin
                    stat_wr_cnt <= stat_wr_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_req_queue.sv
// Directed bench for ddr2_req_queue with a behavioural DDR2 controller (ack/rdy handshake and memory).
module tb_ddr2_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [25:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        c_rd_req;
    logic        c_wr_req;
    logic [25:0] c_addr;
    logic [63:0] c_data_in;
    logic        c_ack;
    logic        c_rdy;
    logic [63:0] c_data_out;
`ifdef DDR2_REQ_QUEUE_STATS_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
`endif

    logic        model_rdy;
    logic        force_busy;
    int          n_checks;
    int          n_fail;
    int          ack_dly;
    int          rdy_dly;
    int          done_cnt;
    logic [90:0] cmd_q [$];
    logic [63:0] mem [logic [25:0]];

    assign c_rdy = model_rdy & !force_busy;

    always #5 clk = ~clk;

    ddr2_req_queue #(.DEPTH(4), .ADDR_W(26), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .c_rd_req   (c_rd_req),
        .c_wr_req   (c_wr_req),
        .c_addr     (c_addr),
        .c_data_in  (c_data_in),
        .c_ack      (c_ack),
        .c_rdy      (c_rdy),
`ifdef DDR2_REQ_QUEUE_STATS_EN
        .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt),
`endif
        .c_data_out (c_data_out)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Controller model: ack after ack_dly cycles, drop c_rdy, re-raise it rdy_dly cycles later
    initial begin : ctrl_model
        logic        we;
        logic [25:0] a;
        logic [63:0] d;
        int          n;
        c_ack      = 1'b0;
        model_rdy  = 1'b1;
        c_data_out = '0;
        done_cnt   = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (c_rd_req || c_wr_req)) begin
                we = c_wr_req;
                a  = c_addr;
                d  = c_data_in;
                cmd_q.push_back({we, a, d});
                n = 0;
                while (n < ack_dly && rst_n) begin @(posedge clk); #1; n++; end
                if (rst_n) begin
                    check("req_hold", 96'({c_wr_req, c_rd_req, c_addr, c_data_in}), 96'({we, !we, a, d}));
                    c_ack     = 1'b1;
                    model_rdy = 1'b0;
                    @(posedge clk); #1;
                    c_ack = 1'b0;
                    check("req_drop", 96'({c_wr_req, c_rd_req}), 96'(0));
                    if (we) mem[a] = d;
                    n = 0;
                    while (n < rdy_dly && rst_n) begin @(posedge clk); #1; n++; end
                    if (rst_n) begin
                        c_data_out = we ? 64'h0 : (mem.exists(a) ? mem[a] : 64'h0);
                        done_cnt++;
                    end
                end
                c_ack     = 1'b0;
                model_rdy = 1'b1;
            end
        end
    end

    task automatic push(input logic we, input logic [25:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 1000) begin @(posedge clk); #1; n++; end
        check(tag, 96'(done_cnt), 96'(target));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
        check(tag, 96'(rsp_valid), 96'(1));
    endtask

    task automatic check_cmd(input int idx, input logic we, input logic [25:0] a, input logic [63:0] d);
        if (idx < cmd_q.size()) check("cmd_order", 96'(cmd_q[idx]), 96'({we, a, d}));
        else check("cmd_missing", 96'(cmd_q.size()), 96'(idx + 1));
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_clear", 96'(rsp_valid), 96'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : main
        int base;
        int d0;
        n_checks   = 0;
        n_fail     = 0;
        ack_dly    = 3;
        rdy_dly    = 10;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        force_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_req", 96'(c_rd_req), 96'(0));
        check("rst_wr_req", 96'(c_wr_req), 96'(0));
        check("rst_addr", 96'(c_addr), 96'(0));
        check("rst_data_in", 96'(c_data_in), 96'(0));
        check("rst_rsp_valid", 96'(rsp_valid), 96'(0));
        check("rst_rsp_data", 96'(rsp_data), 96'(0));
        check("rst_req_ready", 96'(req_ready), 96'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read of the same address, with one-cycle issue latency
        push(1'b1, 26'h2ADBEEF, 64'hF00DBEEFDEADFEED);
        check("lat_edge_t", 96'(c_wr_req), 96'(0));
        push(1'b0, 26'h2ADBEEF, 64'h0);
        check("lat_edge_t1", 96'({c_wr_req, c_rd_req}), 96'(2'b10));
        check("lat_addr", 96'(c_addr), 96'(26'h2ADBEEF));
        wait_done(2, "wr_rd_done");
        check("wr_rd_rsp_valid", 96'(rsp_valid), 96'(1));
        check("wr_rd_rsp_data", 96'(rsp_data), 96'(64'hF00DBEEFDEADFEED));
        check_cmd(0, 1'b1, 26'h2ADBEEF, 64'hF00DBEEFDEADFEED);
        check_cmd(1, 1'b0, 26'h2ADBEEF, 64'h0);
        consume();

        // Fill with c_rdy held low; fifth push must be dropped
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 26'(32'h100 + i), 64'(32'h1000 + i));
        check("full_ready", 96'(req_ready), 96'(0));
        push(1'b1, 26'h1FF, 64'hBAD);
        check("full_ready_hold", 96'(req_ready), 96'(0));
        check("busy_no_issue", 96'({c_wr_req, c_rd_req}), 96'(0));
        force_busy = 1'b0;
        wait_done(6, "fill_drain");
        repeat (20) @(posedge clk);
        #1;
        check("fill_no_fifth", 96'(cmd_q.size()), 96'(6));
        for (int i = 0; i < 4; i++) check_cmd(2 + i, 1'b1, 26'(32'h100 + i), 64'(32'h1000 + i));

        // Push and pop on the same edge at count 3
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 26'(32'h200 + i), 64'(32'h2000 + i));
        force_busy = 1'b0;
        push(1'b1, 26'h203, 64'h2003);
        check("pp_ready", 96'(req_ready), 96'(1));
        check("pp_pop", 96'({c_wr_req, c_addr}), 96'({1'b1, 26'h200}));
        push(1'b1, 26'h204, 64'h2004);
        check("pp_count3", 96'(req_ready), 96'(0));
        wait_done(11, "pp_drain");
        for (int i = 0; i < 5; i++) check_cmd(6 + i, 1'b1, 26'(32'h200 + i), 64'(32'h2000 + i));

        // Response backpressure: second read held until the first response is taken
        push(1'b0, 26'h2ADBEEF, 64'h0);
        push(1'b0, 26'h101, 64'h0);
        wait_rsp("bp_rsp1");
        check("bp_rsp1_data", 96'(rsp_data), 96'(64'hF00DBEEFDEADFEED));
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("bp_blocked_cmds", 96'(cmd_q.size()), 96'(12));
        check("bp_blocked_req", 96'(c_rd_req), 96'(0));
        check("bp_rsp1_held", 96'(rsp_valid), 96'(1));
        consume();
        wait_rsp("bp_rsp2");
        check("bp_rsp2_data", 96'(rsp_data), 96'(64'h1001));
        check("bp_done", 96'(done_cnt), 96'(d0 + 1));
        check_cmd(12, 1'b0, 26'h101, 64'h0);
        consume();
        repeat (3) @(posedge clk);
        #1;

        // Async reset in the middle of a read issue
        ack_dly = 20;
        push(1'b0, 26'h102, 64'h0);
        begin
            int n = 0;
            while (!c_rd_req && n < 10) begin @(posedge clk); #1; n++; end
        end
        check("rst_mid_pre", 96'(c_rd_req), 96'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_req", 96'(c_rd_req), 96'(0));
        check("rst_mid_ready", 96'(req_ready), 96'(1));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 26'h3FF;
        req_wdata = 64'h5555;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        ack_dly   = 3;
        base      = cmd_q.size();
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_replay", 96'(cmd_q.size()), 96'(base));
        check("rst_no_req", 96'({c_wr_req, c_rd_req}), 96'(0));
        check("rst_rsp_valid_post", 96'(rsp_valid), 96'(0));

        // Mixed traffic after reset: 3 writes, 2 reads
        rsp_ready = 1'b1;
        d0 = done_cnt;
`ifdef DDR2_REQ_QUEUE_STATS_EN
        check("stat_rd_rst", 96'(stat_rd_cnt), 96'(0));
        check("stat_wr_rst", 96'(stat_wr_cnt), 96'(0));
`endif
        for (int i = 0; i < 3; i++) push(1'b1, 26'(32'h300 + i), 64'(32'h3000 + i));
        push(1'b0, 26'h300, 64'h0);
        push(1'b0, 26'h301, 64'h0);
        wait_done(d0 + 5, "mix_drain");
        for (int i = 0; i < 3; i++) check_cmd(base + i, 1'b1, 26'(32'h300 + i), 64'(32'h3000 + i));
        check_cmd(base + 3, 1'b0, 26'h300, 64'h0);
        check_cmd(base + 4, 1'b0, 26'h301, 64'h0);
        check("mix_last_rsp", 96'(rsp_data), 96'(64'h3001));
`ifdef DDR2_REQ_QUEUE_STATS_EN
        check("stat_wr_cnt", 96'(stat_wr_cnt), 96'(3));
        check("stat_rd_cnt", 96'(stat_rd_cnt), 96'(2));
`endif
        rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_req_queue.md
Name: ddr2_req_queue

Overview:
- Upstream request front-end for the DDR2 controller user port (c_addr/c_data_in/c_rd_req/c_wr_req/c_ack/c_rdy/c_data_out).
- Buffers client read/write requests in a FIFO and replays them one at a time using the controller's req/ack/rdy handshake.
- Returns read data to the client through a one-entry valid/ready response register.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 26, address width; matches c_addr.
- DATA_W, 64, data width; matches c_data_in/c_data_out.

Ports:
- clk  in  1  system clock (controller clk domain)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  FIFO can accept; equals !full
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  client consumes read data
- rsp_data  out  DATA_W  read data
- c_rd_req  out  1  to controller
- c_wr_req  out  1  to controller
- c_addr  out  ADDR_W  to controller
- c_data_in  out  DATA_W  to controller
- c_ack  in  1  controller accepted the command
- c_rdy  in  1  controller idle / previous command complete
- c_data_out  in  DATA_W  controller read data, valid when c_rdy rises after a read

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE. c_rd_req=0, c_wr_req=0, c_addr=0, c_data_in=0, rsp_valid=0, rsp_data=0. req_ready=1, but pushes are ignored while rst_n=0.
- Push occurs when req_valid && req_ready on a clk edge. Each entry stores {we, addr, wdata}.
- Full: req_ready=0; no push-through, even if a pop happens in the same cycle.
- Push and pop in the same cycle: count unchanged. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from a count of log2(DEPTH)+1 bits.
- All c_* outputs are registered.
- IDLE -> ISSUE when FIFO non-empty && c_rdy==1 && (head is a write || rsp_valid==0):
  - Pop the head.
  - Load c_addr and c_data_in (c_data_in=0 for reads).
  - Assert c_wr_req or c_rd_req.
  - Earliest req assertion is one cycle after the push.
- ISSUE: hold the req signal and c_addr/c_data_in stable until c_ack==1 is sampled. On that edge, deassert req and go to WAIT_LOW.
- WAIT_LOW: wait for c_rdy==0. If c_rdy is already 0 at the ack edge, go directly to WAIT_DONE on the next edge.
- WAIT_DONE: on the first edge with c_rdy==1, return to IDLE. If the command was a read, capture c_data_out into rsp_data and set rsp_valid=1 on that same edge.
- rsp_valid clears on an edge with rsp_ready==1.
- A read is never issued while rsp_valid==1, so there is no response overrun. Writes may still issue.
- Exactly one command is outstanding at any time. c_rd_req and c_wr_req are never both 1.
- Latency: read accepted at edge T on an idle controller → c_rd_req=1 after edge T+1. rsp_valid=1 on the c_rdy rising edge after c_ack.
- Reset mid-command: req, rsp_valid and FIFO clear immediately. The aborted command is not retried.

Optional Feature:
- Macro DDR2_REQ_QUEUE_STATS_EN.
- Defined: adds outputs stat_rd_cnt[15:0] and stat_wr_cnt[15:0].
  - Each increments on the ack edge of its command type.
  - Each saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write then read: push write addr=26'h2ADBEEF, data=64'hF00DBEEFDEADFEED, then read of the same address; controller model acks after 3 cycles and re-raises c_rdy after 10. Required: c_wr_req then c_rd_req, each held until c_ack; c_addr=26'h2ADBEEF; rsp_valid=1 with rsp_data=64'hF00DBEEFDEADFEED.
- Fill: push 5 requests with DEPTH=4 and c_rdy held 0. Required: req_ready=0 after the 4th push; 5th push not accepted; when c_rdy goes 1, entries issue in push order.
- Response backpressure: two reads queued, rsp_ready=0. Required: first read completes; second read not issued until rsp_ready=1 for one cycle.
- Simultaneous push/pop at count 3. Required: count stays 3; req_ready stays 1.
- Async reset: drop rst_n while c_rd_req=1 mid-ISSUE. Required: c_rd_req=0 immediately; after release FIFO is empty and rsp_valid=0.
- With DDR2_REQ_QUEUE_STATS_EN: 3 writes and 2 reads. Required: stat_wr_cnt=3 and stat_rd_cnt=2 after the final ack.
